// File: rtl/uart_rx_if.sv
// Received-byte output channel of the UART receiver: valid/ready handshake plus per-byte status.
// The receiver drives the master side and the consumer drives the slave side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: samples rx at SCALE x baud using Uart_clk as a tick enable, deserialises LSB first,
// and holds each byte with its frame, parity and overrun status until the consumer accepts it.
module uart_rx #(
  parameter int SCALE      = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic      src_clk,
  input  logic      rst_n,
  input  logic      Uart_clk,
  input  logic      rx,
  uart_rx_if.master out_if,
  output logic      busy
);

  localparam int                SAMP_W    = $clog2(SCALE);
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(SCALE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SCALE - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [SAMP_W-1:0]     samp_q, samp_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_out_q, perr_out_d;
  logic                  ovr_q, ovr_d;
  logic                  rx_meta_q, rx_s_q;
  logic                  uart_clk_q;
  logic                  tick;
  logic                  load;

  assign tick = Uart_clk & ~uart_clk_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      uart_clk_q <= 1'b0;
      state_q    <= IDLE;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      uart_clk_q <= Uart_clk;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted to hold first, so no path can infer a latch.
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    ovr_d      = ovr_q;
    load       = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            samp_d  = '0;
          end
        end
        START: begin
          if (samp_q == SAMP_MID) begin
            samp_d = '0;
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bit_d   = '0;
              perr_d  = 1'b0;
            end
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        DATA: begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 4'd1;
            if (bit_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        PARITY: begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            perr_d  = ((^shift_q) ^ rx_s_q) != (PARITY_ODD != 0);
            state_d = STOP;
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        STOP: begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            state_d = IDLE;
            load    = 1'b1;
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A byte that completes while the previous one is still unaccepted is dropped.
    if (load) begin
      if (!valid_q || out_if.rx_ready) begin
        data_d     = shift_q;
        ferr_d     = ~rx_s_q;
        perr_out_d = perr_q;
        valid_d    = 1'b1;
        ovr_d      = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_if.rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign out_if.rx_data    = data_q;
  assign out_if.rx_valid   = valid_q;
  assign out_if.frame_err  = ferr_q;
  assign out_if.parity_err = perr_out_q;
  assign out_if.overrun    = ovr_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected bytes are queued as they are
// sent, and monitors pop and compare each byte the receivers hand over.
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_clk = 1'b0;
  logic div = 1'b0;
  logic rx, rx_p;
  logic busy, busy_p;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t sb_p[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx_if #(.DATA_BITS(8)) bus_p ();

  uart_rx #(.SCALE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .src_clk(clk), .rst_n(rst_n), .Uart_clk(uart_clk), .rx(rx),
    .out_if(bus.master), .busy(busy)
  );

  uart_rx #(.SCALE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .src_clk(clk), .rst_n(rst_n), .Uart_clk(uart_clk), .rx(rx_p),
    .out_if(bus_p.master), .busy(busy_p)
  );

  always #5 clk = ~clk;

  // Uart_clk toggles every 2 src_clk cycles: one sample tick per 4 cycles.
  always @(posedge clk) begin
    div <= ~div;
    if (div) uart_clk <= ~uart_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", 32'(bus.rx_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        check("frame_err", 32'(bus.frame_err), 32'(e.ferr));
        check("parity_err", 32'(bus.parity_err), 32'(e.perr));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_p.rx_valid === 1'b1 && bus_p.rx_ready === 1'b1) begin
      if (sb_p.size() == 0) begin
        check("p_unexpected_byte", 32'(bus_p.rx_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_p.pop_front();
        check("p_rx_data", 32'(bus_p.rx_data), 32'(e.data));
        check("p_frame_err", 32'(bus_p.frame_err), 32'(e.ferr));
        check("p_parity_err", 32'(bus_p.parity_err), 32'(e.perr));
      end
    end
  end

  task automatic put_bit(input bit to_p, input logic v);
    @(negedge clk);
    if (to_p) rx_p = v;
    else rx = v;
    repeat (63) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit to_p, input logic [7:0] data, input logic stop,
                            input logic with_par, input logic par_bit, input bit expect_out);
    exp_t e;
    e.data = data;
    e.ferr = ~stop;
    e.perr = with_par ? ((^data) ^ par_bit) : 1'b0;
    if (expect_out) begin
      if (to_p) sb_p.push_back(e);
      else sb.push_back(e);
    end
    put_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(to_p, data[i]);
    if (with_par) put_bit(to_p, par_bit);
    put_bit(to_p, stop);
    @(negedge clk);
    if (to_p) rx_p = 1'b1;
    else rx = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rx_p = 1'b1;
    bus.rx_ready = 1'b1;
    bus_p.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_data", 32'(bus.rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    rst_n = 1'b1;
    idle(16);

    // Good frame with the consumer always ready.
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(64);
    check("t1_drain", 32'(sb.size()), 32'd0);
    check("t1_valid_low", 32'(bus.rx_valid), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);

    // Short low pulse is rejected at the mid-start sample.
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    check("t2_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(64);
    check("t2_busy_low", 32'(busy), 32'd0);
    check("t2_valid_low", 32'(bus.rx_valid), 32'd0);

    // Bad stop bit, then a clean frame.
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(128);
    send_frame(1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(64);
    check("t3_drain", 32'(sb.size()), 32'd0);

    // Overrun: second byte arrives while the first is still held.
    bus.rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(32);
    check("t4_valid_held", 32'(bus.rx_valid), 32'd1);
    check("t4_no_overrun", 32'(bus.overrun), 32'd0);
    send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(32);
    check("t4_data_kept", 32'(bus.rx_data), 32'h11);
    check("t4_overrun", 32'(bus.overrun), 32'd1);
    @(posedge clk);
    #1 bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_cleared", 32'(bus.rx_valid), 32'd0);
    check("t4_overrun_cleared", 32'(bus.overrun), 32'd0);
    check("t4_drain", 32'(sb.size()), 32'd0);
    idle(16);

    // Even parity on the parity-enabled receiver.
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(64);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(64);
    check("t5_drain", 32'(sb_p.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF discards the frame.
    put_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b0, 1'b1);
    @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_busy_reset", 32'(busy), 32'd0);
    check("t6_data_reset", 32'(bus.rx_data), 32'd0);
    idle(5 * 64);
    check("t6_no_valid", 32'(bus.rx_valid), 32'd0);
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(64);
    check("t6_drain", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
